// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC core sequencer.
// Opcodes, state encoding and opcode classes.
package risc_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LW  = 4'h1;
  localparam logic [3:0] OP_SW  = 4'h2;
  localparam logic [3:0] OP_BEQ = 4'h9;
  localparam logic [3:0] OP_BNE = 4'ha;
  localparam logic [3:0] OP_J   = 4'hb;
  localparam logic [3:0] OP_INC = 4'hc;
  localparam logic [3:0] OP_DEC = 4'hd;
  localparam logic [3:0] OP_CLR = 4'he;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_NOP,
    C_LW,
    C_SW,
    C_ALU,
    C_BEQ,
    C_BNE,
    C_J
  } opclass_t;

endpackage

// File: rtl/risc_opcode_class.sv
// Opcode to instruction-class map.
// Everything not explicitly listed is ALU.
import risc_pkg::*;

module risc_opcode_class (
  input  logic [3:0] opcode,
  output opclass_t   cls
);

  // classify the opcode field
  always_comb begin
    cls = C_ALU;
    unique case (1'b1)
      (opcode == OP_NOP): cls = C_NOP;
      (opcode == OP_LW):  cls = C_LW;
      (opcode == OP_SW):  cls = C_SW;
      (opcode == OP_BEQ): cls = C_BEQ;
      (opcode == OP_BNE): cls = C_BNE;
      (opcode == OP_J):   cls = C_J;
      default:            cls = C_ALU;
    endcase
  end

endmodule

// File: rtl/risc_multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer.
// Strobes decode from state plus same-cycle acks.
import risc_pkg::*;

module risc_multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic             zero_flag,
  input  logic             stall,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  input  logic             dmem_ack,
  output logic             dmem_we,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_branch,
  output logic             pc_jump,
  output logic             rf_we,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic             timeout_err
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t         st;
  opclass_t       cls;
  logic [7:0]     wcnt;
  logic [CNT_W-1:0] cnt;
  logic           terr;
  logic           retire;
  logic           is_br;
  logic           is_mem;

  risc_opcode_class u_cls (
    .opcode (opcode),
    .cls    (cls)
  );

  assign is_br  = (cls == C_BEQ) || (cls == C_BNE);
  assign is_mem = (cls == C_LW) || (cls == C_SW);

  // strobe and request decode; everything is low in reset
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_branch = 1'b0;
    pc_jump   = 1'b0;
    rf_we     = 1'b0;
    retire    = 1'b0;
    if (!rst) begin
      unique case (st)
        S_FETCH: begin
          if (!stall) begin
            imem_req = 1'b1;
            ir_load  = imem_ack;
          end
        end
        S_DECODE: begin
          if (cls == C_NOP) begin
            pc_inc = 1'b1;
            retire = 1'b1;
          end else if (cls == C_J) begin
            pc_jump = 1'b1;
            retire  = 1'b1;
          end
        end
        S_EXEC: begin
          if (cls == C_BEQ) begin
            pc_branch = zero_flag;
            pc_inc    = !zero_flag;
            retire    = 1'b1;
          end else if (cls == C_BNE) begin
            pc_branch = !zero_flag;
            pc_inc    = zero_flag;
            retire    = 1'b1;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls == C_SW);
          if (dmem_ack && cls == C_SW) begin
            pc_inc = 1'b1;
            retire = 1'b1;
          end
        end
        S_WB: begin
          rf_we  = 1'b1;
          pc_inc = 1'b1;
          retire = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // state, wait counter, retire counter and sticky timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= S_FETCH;
      wcnt <= '0;
      cnt  <= '0;
      terr <= 1'b0;
    end else begin
      if (retire) cnt <= cnt + CNT_W'(1);
      unique case (st)
        S_FETCH: begin
          if (!stall && imem_ack) st <= S_DECODE;
        end
        S_DECODE: begin
          if (cls == C_NOP || cls == C_J) st <= S_FETCH;
          else st <= S_EXEC;
        end
        S_EXEC: begin
          wcnt <= '0;
          if (is_br) st <= S_FETCH;
          else if (is_mem) st <= S_MEM;
          else st <= S_WB;
        end
        S_MEM: begin
          if (dmem_ack) begin
            st <= (cls == C_SW) ? S_FETCH : S_WB;
          end else if (wcnt == WAIT_LAST) begin
            terr <= 1'b1;
            st   <= S_HALT;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        S_WB: st <= S_FETCH;
        default: st <= S_HALT;
      endcase
    end
  end

  assign state       = rst ? 3'd0 : st;
  assign instr_count = rst ? '0 : cnt;
  assign timeout_err = rst ? 1'b0 : terr;

endmodule

// File: tb/tb_risc_multicycle_sequencer.sv
// Directed bench for the multi-cycle sequencer.
// Retire strobes and counts are checked against a queue.
module tb_risc_multicycle_sequencer;

  localparam int CW = 4;
  localparam int TO = 4;

  localparam logic [7:0] IREQ = 8'h80;
  localparam logic [7:0] DREQ = 8'h40;
  localparam logic [7:0] DWE  = 8'h20;
  localparam logic [7:0] IRL  = 8'h10;
  localparam logic [7:0] PINC = 8'h08;
  localparam logic [7:0] PBR  = 8'h04;
  localparam logic [7:0] PJ   = 8'h02;
  localparam logic [7:0] RFW  = 8'h01;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    opcode;
  logic          zero_flag;
  logic          stall;
  logic          imem_req;
  logic          imem_ack;
  logic          dmem_req;
  logic          dmem_ack;
  logic          dmem_we;
  logic          ir_load;
  logic          pc_inc;
  logic          pc_branch;
  logic          pc_jump;
  logic          rf_we;
  logic [2:0]    state;
  logic [CW-1:0] instr_count;
  logic          timeout_err;

  risc_multicycle_sequencer #(
    .MEM_TIMEOUT (TO),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .zero_flag   (zero_flag),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .dmem_req    (dmem_req),
    .dmem_ack    (dmem_ack),
    .dmem_we     (dmem_we),
    .ir_load     (ir_load),
    .pc_inc      (pc_inc),
    .pc_branch   (pc_branch),
    .pc_jump     (pc_jump),
    .rf_we       (rf_we),
    .state       (state),
    .instr_count (instr_count),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pat;
    int         cnt;
  } sb_t;

  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;
  logic pend_v = 1'b0;
  int   pend_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_retire(input logic [7:0] pat);
    sb_t e;
    model_cnt = (model_cnt + 1) % (1 << CW);
    e.pat = pat[3:0];
    e.cnt = model_cnt;
    sb.push_back(e);
  endtask

  // one clock: compare strobes mid-cycle, pop on retire
  task automatic cyc(input string tag, input logic [7:0] exp);
    logic [7:0] o;
    sb_t e;
    @(negedge clk);
    if (pend_v) begin
      chk({tag, "/count"}, 32'(instr_count), 32'(pend_cnt));
      pend_v = 1'b0;
    end
    o = {imem_req, dmem_req, dmem_we, ir_load,
         pc_inc, pc_branch, pc_jump, rf_we};
    chk(tag, 32'(o), 32'(exp));
    if (|o[3:1]) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL %s/unexpected_retire observed=%0h expected=none",
               tag, o);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({tag, "/retire"}, 32'(o[3:0]), 32'(e.pat));
        pend_v   = 1'b1;
        pend_cnt = e.cnt;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag);
    imem_ack = 1'b1;
    cyc(tag, IREQ | IRL);
    imem_ack = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    stall     = 1'b0;
    imem_ack  = 1'b1;
    dmem_ack  = 1'b1;
    zero_flag = 1'b0;
    opcode    = 4'h0;
    #1;
    cyc("rst_a", 8'h00);
    cyc("rst_b", 8'h00);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    rst      = 1'b0;

    // reset while in MEM: discarded, not retired
    opcode = 4'h2;
    fetch("swr_fetch");
    cyc("swr_dec", 8'h00);
    cyc("swr_exec", 8'h00);
    cyc("swr_mem1", DREQ | DWE);
    chk("swr_in_mem", 32'(state), 32'd3);
    rst = 1'b1;
    cyc("swr_rst", 8'h00);
    rst = 1'b0;
    chk("swr_state", 32'(state), 32'd0);
    chk("swr_count", 32'(instr_count), 32'd0);
    cyc("swr_ireq", IREQ);

    // ALU, zero-wait
    opcode = 4'h3;
    fetch("alu_fetch");
    chk("alu_decode_st", 32'(state), 32'd1);
    cyc("alu_dec", 8'h00);
    cyc("alu_exec", 8'h00);
    push_retire(PINC | RFW);
    cyc("alu_wb", PINC | RFW);

    // LW, ack in 4th MEM cycle
    opcode = 4'h1;
    fetch("lw_fetch");
    cyc("lw_dec", 8'h00);
    cyc("lw_exec", 8'h00);
    repeat (3) cyc("lw_wait", DREQ);
    dmem_ack = 1'b1;
    cyc("lw_ack", DREQ);
    dmem_ack = 1'b0;
    push_retire(PINC | RFW);
    cyc("lw_wb", PINC | RFW);

    // BEQ/BNE with both zero_flag values
    for (int i = 0; i < 4; i++) begin
      logic bne;
      logic taken;
      bne       = (i >= 2);
      zero_flag = (i % 2 == 1);
      taken     = bne ? !zero_flag : zero_flag;
      opcode    = bne ? 4'ha : 4'h9;
      fetch("br_fetch");
      cyc("br_dec", 8'h00);
      push_retire(taken ? PBR : PINC);
      cyc("br_exec", taken ? PBR : PINC);
    end
    zero_flag = 1'b0;

    // SW, ack in the last allowed wait cycle
    opcode = 4'h2;
    fetch("sw_fetch");
    cyc("sw_dec", 8'h00);
    cyc("sw_exec", 8'h00);
    repeat (TO - 1) cyc("sw_wait", DREQ | DWE);
    dmem_ack = 1'b1;
    push_retire(PINC);
    cyc("sw_ack", DREQ | DWE | PINC);
    dmem_ack = 1'b0;
    chk("sw_terr", 32'(timeout_err), 32'd0);

    // stall in FETCH with stray acks
    stall    = 1'b1;
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    repeat (5) cyc("stall", 8'h00);
    chk("stall_state", 32'(state), 32'd0);
    stall    = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    cyc("unstall", IREQ);

    // NOPs up to the counter maximum
    opcode = 4'h0;
    while (model_cnt != (1 << CW) - 1) begin
      fetch("nop_fetch");
      push_retire(PINC);
      cyc("nop_dec", PINC);
    end

    // J wraps the counter
    opcode = 4'hb;
    fetch("j_fetch");
    push_retire(PJ);
    cyc("j_dec", PJ);
    cyc("j_idle", IREQ);
    chk("wrap_count", 32'(instr_count), 32'd0);

    // SW timeout into HALT
    opcode = 4'h2;
    fetch("to_fetch");
    cyc("to_dec", 8'h00);
    cyc("to_exec", 8'h00);
    repeat (TO) cyc("to_wait", DREQ | DWE);
    chk("to_state", 32'(state), 32'd5);
    chk("to_terr", 32'(timeout_err), 32'd1);
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    repeat (3) cyc("halt", 8'h00);
    chk("halt_state", 32'(state), 32'd5);
    chk("halt_terr", 32'(timeout_err), 32'd1);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/risc_multicycle_sequencer.md
# risc_multicycle_sequencer

Multi-cycle instruction sequencer for the 16-bit RISC core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB states. It drives the instruction- and data-memory request handshakes and issues the single-cycle PC, IR and register-file strobes. It sits beside the combinational opcode decoder and gates that decoder's static controls into time-correct enables. It also counts retired instructions and traps data-memory timeouts.

## Interface
- `MEM_TIMEOUT`, 15: maximum cycles in MEM waiting for `dmem_ack`; range 1..255.
- `CNT_W`, 16: width of the retired-instruction counter.

- `clk` in 1: the single clock; every register is updated on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `opcode` in 4: IR[15:12]; valid from DECODE onward.
- `zero_flag` in 1: ALU zero result; valid in EXEC.
- `stall` in 1: hold at the instruction boundary.
- `imem_req` out 1 / `imem_ack` in 1: instruction-fetch handshake.
- `dmem_req` out 1 / `dmem_ack` in 1: data-memory handshake.
- `dmem_we` out 1: write qualifier; only meaningful while `dmem_req`=1.
- `ir_load` out 1: load the IR.
- `pc_inc` out 1: PC ← PC+2.
- `pc_branch` out 1: PC ← branch target.
- `pc_jump` out 1: PC ← jump target.
- `rf_we` out 1: register-file write enable.
- `state` out 3: current state encoding, for debug.
- `instr_count` out CNT_W: number of retired instructions.
- `timeout_err` out 1: sticky data-memory timeout flag.

## Operation
Opcode classes:
- NOP = 0000.
- LW = 0001.
- SW = 0010.
- ALU = 0011–1000, 1100 (INC), 1101 (DEC), 1110 (CLR), and 1111.
- BEQ = 1001.
- BNE = 1010.
- J = 1011.

State transitions:
- **FETCH**
  - If `stall`=1: `imem_req`=0, `imem_ack` ignored, hold in FETCH.
  - Else `imem_req`=1. When `imem_ack`=1: `ir_load`=1 in the same cycle, go to DECODE. Otherwise hold.
- **DECODE**
  - NOP: `pc_inc`, retire, go to FETCH.
  - J: `pc_jump`, retire, go to FETCH.
  - All other classes: go to EXEC.
- **EXEC**
  - BEQ: if `zero_flag`=1, `pc_branch`; else `pc_inc`. Retire, go to FETCH.
  - BNE: if `zero_flag`=0, `pc_branch`; else `pc_inc`. Retire, go to FETCH.
  - LW/SW: go to MEM.
  - ALU class: go to WB.
- **MEM**
  - `dmem_req`=1. `dmem_we`=1 for SW, 0 for LW. Request is held until `dmem_ack`.
  - On ack: SW → `pc_inc`, retire, go to FETCH. LW → go to WB.
  - Wait counter is cleared on MEM entry and increments each cycle without ack.
  - An ack arriving in wait cycle ≤ `MEM_TIMEOUT` is accepted.
  - If cycle `MEM_TIMEOUT` ends without ack: set `timeout_err`, drop `dmem_req`, go to HALT.
- **WB**: `rf_we`=1, `pc_inc`, retire, go to FETCH.
- **HALT**: all strobes and requests are 0. Exit only through `rst`.

Rules:
- "Retire" means `instr_count` increments by 1, wrapping modulo 2^CNT_W.
- At most one of `pc_inc`/`pc_branch`/`pc_jump` is high in any cycle.
- Each strobe is high for exactly one cycle per instruction.
- Acks arriving while the matching request is low are ignored.
- `timeout_err` clears only on `rst`.

## Timing
- Reset values:
  - `state` = FETCH.
  - `instr_count` = 0.
  - `timeout_err` = 0.
  - Wait counter = 0.
  - All outputs are forced to 0 while `rst`=1.
- `imem_req` rises in the first cycle after `rst` falls, provided `stall`=0.
- Latency with zero-wait acks, in cycles from `imem_req` to the retire strobe inclusive:
  - NOP/J: 2.
  - Branch: 3.
  - ALU: 4.
  - SW: 4.
  - LW: 5.
- Each wait cycle on either memory adds 1 cycle.
- Outputs are Moore-decoded from `state`, plus same-cycle `imem_ack`/`dmem_ack`, `opcode` and `zero_flag`.
- `stall` is sampled only in FETCH. Once the FSM is past FETCH, the instruction always completes.
- `rst` asserted mid-instruction: next state is FETCH, any partial instruction is discarded and not retired, and outstanding requests drop immediately.

## Structure
- Shared package `risc_pkg` holds:
  - opcode localparams (NOP, LW, SW, BEQ, BNE, J, INC, DEC, CLR);
  - the state encoding (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5);
  - the opcode-class enum.
- Sub-module `risc_opcode_class`: combinational map from opcode to class {NOP, LW, SW, ALU, BEQ, BNE, J}.
- The FSM, wait counter and retire counter live in the top module.

## Test plan
- ALU instruction (opcode 0011), zero-wait acks: `ir_load` at cycle 1, `rf_we`+`pc_inc` at cycle 4, `instr_count` 0→1.
- LW with `dmem_ack` delayed 3 cycles: `dmem_req` high for 4 cycles with `dmem_we`=0, then `rf_we` one cycle later; total 8 cycles.
- BEQ with `zero_flag`=1 → `pc_branch` in EXEC. BNE with `zero_flag`=1 → `pc_inc`, no `pc_branch`.
- SW with `MEM_TIMEOUT`=4 and no ack: `dmem_req` high exactly 4 cycles, then `timeout_err`=1, state=HALT, no further requests; an ack in wait cycle 4 (set up as a separate case) is accepted.
- `stall`=1 in FETCH for 5 cycles: `imem_req`=0 and a stray `imem_ack` is ignored. `rst` pulse during MEM: FETCH next cycle, `instr_count` unchanged.
- Preload `instr_count`=2^CNT_W−1, retire a J: count wraps to 0 and `pc_jump` is high at cycle 2.
